// File: rtl/morse_pkg.sv
// Definitions shared by the Morse trainer blocks: the round-controller state set,
// the timebase constants and the counter widths.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LETTER,
        LISTEN,
        SHOW,
        DONE
    } round_state_e;

    // Timebase shared with the decoder: tick_i runs at TICK_HZ; symbol lengths are in ticks
    localparam int TICK_HZ        = 100;
    localparam int DOT_TICKS      = 12;
    localparam int DASH_TICKS     = 36;
    localparam int CHAR_GAP_TICKS = 36;

    localparam int TICK_CNT_W = 8;
    localparam int WAIT_CNT_W = 4;
    localparam int ROUND_W    = 5;

    function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] v);
        return (v == {ROUND_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/morse_round_ctrl_if.sv
// Signal bundle between the round controller and its surroundings
// (start switch, letter generator, decoder, result LEDs).
interface morse_round_ctrl_if;
    import morse_pkg::*;

    logic               tick_i;
    logic               start_i;
    logic               letter_req_o;
    logic               letter_ready_i;
    logic               dec_en_o;
    logic               dec_done_i;
    logic               dec_correct_i;
    logic [ROUND_W-1:0] round_o;
    logic [ROUND_W-1:0] score_o;
    logic               result_valid_o;
    logic               result_ok_o;
    logic               game_over_o;
    logic               busy_o;

    modport master (
        input  tick_i, start_i, letter_ready_i, dec_done_i, dec_correct_i,
        output letter_req_o, dec_en_o, round_o, score_o,
               result_valid_o, result_ok_o, game_over_o, busy_o
    );

    modport slave (
        output tick_i, start_i, letter_ready_i, dec_done_i, dec_correct_i,
        input  letter_req_o, dec_en_o, round_o, score_o,
               result_valid_o, result_ok_o, game_over_o, busy_o
    );

endinterface

// File: rtl/morse_tick_timer.sv
// Loadable down-counter on the tick strobe; expire_o flags the tick that
// exhausts the loaded count, so the owner can act in that same cycle.
module morse_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = tick_i && (cnt_q == W'(1));

endmodule

// File: rtl/morse_round_ctrl.sv
// Quiz round sequencer: requests a letter, enables the decoder, collects the verdict
// or a timeout, shows the per-round result and keeps score for a fixed-length game.
module morse_round_ctrl
    import morse_pkg::*;
#(
    parameter int NUM_ROUNDS    = 10,
    parameter int TIMEOUT_TICKS = 250,
    parameter int HOLD_TICKS    = 100,
    parameter int REQ_TIMEOUT   = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    morse_round_ctrl_if.master bus
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("morse_round_ctrl: NUM_ROUNDS must be 1..31");
    end
    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
        $error("morse_round_ctrl: TIMEOUT_TICKS must be 1..255");
    end
    if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold
        $error("morse_round_ctrl: HOLD_TICKS must be 1..255");
    end
    if (REQ_TIMEOUT < 1 || REQ_TIMEOUT > 15) begin : g_bad_req_timeout
        $error("morse_round_ctrl: REQ_TIMEOUT must be 1..15");
    end

    localparam logic [ROUND_W-1:0]    LAST_ROUND  = ROUND_W'(NUM_ROUNDS);
    localparam logic [TICK_CNT_W-1:0] LISTEN_LEN  = TICK_CNT_W'(TIMEOUT_TICKS);
    localparam logic [TICK_CNT_W-1:0] HOLD_LEN    = TICK_CNT_W'(HOLD_TICKS);
    localparam logic [WAIT_CNT_W-1:0] REQ_WAIT    = WAIT_CNT_W'(REQ_TIMEOUT);

    round_state_e        state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [ROUND_W-1:0]  score_q, score_d;
    logic                ok_q, ok_d;

    logic                   start_s;
    logic                   start_rise;
    logic                   tmr_load;
    logic [TICK_CNT_W-1:0]  tmr_val;
    logic                   tmr_expire;

    // Two flops of metastability protection, third flop for edge detection
    assign sync_d     = {sync_q[1:0], bus.start_i};
    assign start_s    = sync_q[1];
    assign start_rise = sync_q[1] & ~sync_q[2];

    morse_tick_timer #(.W(TICK_CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tick_i     (bus.tick_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        round_d    = round_q;
        score_d    = score_q;
        ok_d       = ok_q;
        tmr_load   = 1'b0;
        tmr_val    = LISTEN_LEN;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    score_d = '0;
                    round_d = ROUND_W'(1);
                    ok_d    = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                wait_cnt_d = '0;
                state_d    = WAIT_LETTER;
            end
            WAIT_LETTER: begin
                if (bus.letter_ready_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = LISTEN_LEN;
                    state_d  = LISTEN;
                end else if (wait_cnt_q == REQ_WAIT) begin
                    state_d = REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            // A verdict arriving on the final timeout tick still counts
            LISTEN: begin
                if (bus.dec_done_i) begin
                    ok_d     = bus.dec_correct_i;
                    score_d  = bus.dec_correct_i ? sat_inc(score_q) : score_q;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LEN;
                    state_d  = SHOW;
                end else if (tmr_expire) begin
                    ok_d     = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LEN;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (tmr_expire) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Switch dropped mid-game abandons the game entirely
        if ((state_q inside {REQ, WAIT_LETTER, LISTEN, SHOW}) && !start_s) begin
            state_d = IDLE;
            round_d = '0;
            score_d = '0;
            ok_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            wait_cnt_q <= '0;
            round_q    <= '0;
            score_q    <= '0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            wait_cnt_q <= wait_cnt_d;
            round_q    <= round_d;
            score_q    <= score_d;
            ok_q       <= ok_d;
        end
    end

    assign bus.letter_req_o   = (state_q == REQ);
    assign bus.dec_en_o       = (state_q == LISTEN);
    assign bus.result_valid_o = (state_q == SHOW);
    assign bus.result_ok_o    = ok_q;
    assign bus.game_over_o    = (state_q == DONE);
    assign bus.busy_o         = (state_q != IDLE) && (state_q != DONE);
    assign bus.round_o        = round_q;
    assign bus.score_o        = score_q;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Randomised scoreboard bench for morse_round_ctrl: stimulus pushes expected round
// results from a score/round model, a negedge monitor pops them as the DUT shows them.
module tb_morse_round_ctrl;

    localparam int NR       = 3;
    localparam int TO       = 5;
    localparam int HOLD     = 3;
    localparam int RQ       = 15;
    localparam int TICK_DIV = 3;

    typedef struct {
        int kind;
        int ok;
        int score;
        int round;
        int ticks;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t sbq[$];
    exp_t mon_e;
    int   req_cnt      = 0;
    int   listen_ticks = 0;
    int   model_round  = 0;
    int   model_score  = 0;
    bit   prev_valid   = 1'b0;
    bit   prev_over    = 1'b0;
    bit   prev_en      = 1'b0;

    morse_round_ctrl_if bus();

    morse_round_ctrl #(
        .NUM_ROUNDS    (NR),
        .TIMEOUT_TICKS (TO),
        .HOLD_TICKS    (HOLD),
        .REQ_TIMEOUT   (RQ)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sigNow(input int which);
        case (which)
            0:       return bus.letter_req_o;
            1:       return bus.dec_en_o;
            2:       return bus.result_valid_o;
            3:       return bus.game_over_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitFor(input int which, input string name);
        int n = 0;
        while (!sigNow(which) && n < 400) begin
            step();
            n++;
        end
        if (!sigNow(which)) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    // Score/round model: a correct verdict adds one point (capped at 31)
    task automatic pushExpect(input int ok, input int ticks);
        exp_t e;
        if (ok != 0 && model_score < 31) model_score++;
        e.kind  = 0;
        e.ok    = ok;
        e.score = model_score;
        e.round = model_round;
        e.ticks = ticks;
        sbq.push_back(e);
        if (model_round == NR) begin
            e.kind  = 1;
            e.ok    = 0;
            e.ticks = 0;
            sbq.push_back(e);
        end
    endtask

    // Timebase: one tick every TICK_DIV cycles, predictable from cyc
    initial begin
        bus.tick_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tick_i = (cyc % TICK_DIV == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.letter_req_o) req_cnt++;
            if (bus.dec_en_o && !prev_en) listen_ticks = 0;
            if (bus.dec_en_o && bus.tick_i) listen_ticks++;
            if (bus.result_valid_o && !prev_valid) begin
                if (sbq.size() == 0 || sbq[0].kind != 0) begin
                    checkOutput("sb_unexpected_result", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("result_ok", bus.result_ok_o, mon_e.ok);
                    checkOutput("result_score", bus.score_o, mon_e.score);
                    checkOutput("result_round", bus.round_o, mon_e.round);
                    if (mon_e.ticks < 0) checkOutput("listen_ticks_below_timeout", int'(listen_ticks < TO), 1);
                    else checkOutput("listen_ticks", listen_ticks, mon_e.ticks);
                end
            end
            if (bus.game_over_o && !prev_over) begin
                if (sbq.size() == 0 || sbq[0].kind != 1) begin
                    checkOutput("sb_unexpected_game_over", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("final_score", bus.score_o, mon_e.score);
                    checkOutput("final_round", bus.round_o, mon_e.round);
                    checkOutput("final_busy", bus.busy_o, 0);
                end
            end
            prev_valid = bus.result_valid_o;
            prev_over  = bus.game_over_o;
            prev_en    = bus.dec_en_o;
        end
    end

    task automatic startGame(input bit from_done);
        bus.start_i = 1'b0;
        repeat (4) step();
        if (from_done) checkOutput("done_holds_with_switch_low", bus.game_over_o, 1);
        bus.start_i = 1'b1;
        req_cnt     = 0;
        model_round = 1;
        model_score = 0;
        step();
        step();
        checkOutput("req_latency_early", bus.letter_req_o, 0);
        step();
        checkOutput("req_latency", bus.letter_req_o, 1);
        checkOutput("start_round", bus.round_o, 1);
        checkOutput("start_score", bus.score_o, 0);
    endtask

    // mode 0: answer early, 1: no answer (timeout), 2: answer on the final timeout tick
    task automatic applyStimulus(input int mode, input int correct, input int ready_delay,
                                 output int extra);
        int c0;
        int t;
        int n;
        extra = 0;
        waitFor(0, "letter_req");
        c0 = cyc;
        for (int i = 1; i <= ready_delay; i++) begin
            step();
            checkOutput("no_listen_before_ready", bus.dec_en_o, 0);
            if (bus.letter_req_o) begin
                extra++;
                // one REQ cycle plus REQ_TIMEOUT+1 unanswered waiting cycles
                checkOutput("rereq_offset", cyc - c0, (RQ + 2) * extra);
            end
        end
        bus.letter_ready_i = 1'b1;
        waitFor(1, "dec_en");
        bus.letter_ready_i = 1'b0;
        if (mode == 0) begin
            repeat ($urandom_range(0, 6)) step();
            bus.dec_done_i    = 1'b1;
            bus.dec_correct_i = correct[0];
            pushExpect(correct, -1);
            step();
            bus.dec_done_i    = 1'b0;
            bus.dec_correct_i = 1'b0;
        end else if (mode == 1) begin
            pushExpect(0, TO);
            waitFor(2, "show_after_timeout");
            bus.dec_done_i    = 1'b1;
            bus.dec_correct_i = 1'b1;
            step();
            bus.dec_done_i    = 1'b0;
            bus.dec_correct_i = 1'b0;
        end else begin
            t = 0;
            n = 0;
            forever begin
                if (cyc % TICK_DIV == 0) t++;
                if (t >= TO || n > 100) break;
                step();
                n++;
            end
            bus.dec_done_i    = 1'b1;
            bus.dec_correct_i = correct[0];
            pushExpect(correct, TO);
            step();
            bus.dec_done_i    = 1'b0;
            bus.dec_correct_i = 1'b0;
        end
        if (model_round < NR) model_round++;
    endtask

    task automatic finishGame(input int extra);
        waitFor(3, "game_over");
        checkOutput("req_count", req_cnt, NR + extra);
        checkOutput("over_round", bus.round_o, NR);
    endtask

    initial begin
        int ex;
        int ex_sum;
        int n;
        bus.start_i        = 1'b0;
        bus.letter_ready_i = 1'b0;
        bus.dec_done_i     = 1'b0;
        bus.dec_correct_i  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_letter_req", bus.letter_req_o, 0);
        checkOutput("rst_dec_en", bus.dec_en_o, 0);
        checkOutput("rst_round", bus.round_o, 0);
        checkOutput("rst_score", bus.score_o, 0);
        checkOutput("rst_result_valid", bus.result_valid_o, 0);
        checkOutput("rst_game_over", bus.game_over_o, 0);
        checkOutput("rst_busy", bus.busy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] game A: verdicts 1,0,1");
        startGame(1'b0);
        ex_sum = 0;
        applyStimulus(0, 1, 2, ex); ex_sum += ex;
        applyStimulus(0, 0, 2, ex); ex_sum += ex;
        applyStimulus(0, 1, 2, ex); ex_sum += ex;
        finishGame(ex_sum);
        checkOutput("gameA_score", bus.score_o, 2);
        checkOutput("gameA_round", bus.round_o, 3);
        checkOutput("gameA_req_pulses", req_cnt, 3);

        $display("[TB] game B: timeout, coincident verdict, letter re-requests");
        startGame(1'b1);
        ex_sum = 0;
        applyStimulus(1, 0, 3, ex);  ex_sum += ex;
        applyStimulus(2, 1, 1, ex);  ex_sum += ex;
        applyStimulus(0, 1, 40, ex); ex_sum += ex;
        checkOutput("rereq_count", ex, 2);
        finishGame(ex_sum);
        checkOutput("gameB_score", bus.score_o, 2);

        $display("[TB] game C: abort during round 2 result");
        startGame(1'b1);
        applyStimulus(0, 1, 1, ex);
        applyStimulus(0, $urandom_range(0, 1), 1, ex);
        waitFor(2, "show_round2");
        bus.start_i = 1'b0;
        n = 0;
        while (bus.busy_o && n < 10) begin
            step();
            n++;
        end
        checkOutput("abort_latency", n, 3);
        checkOutput("abort_round", bus.round_o, 0);
        checkOutput("abort_score", bus.score_o, 0);
        checkOutput("abort_dec_en", bus.dec_en_o, 0);
        checkOutput("abort_game_over", bus.game_over_o, 0);
        startGame(1'b0);
        ex_sum = 0;
        for (int r = 0; r < NR; r++) begin
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 5), ex);
            ex_sum += ex;
        end
        finishGame(ex_sum);

        $display("[TB] random games");
        for (int g = 0; g < 3; g++) begin
            startGame(1'b1);
            ex_sum = 0;
            for (int r = 0; r < NR; r++) begin
                applyStimulus($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 5), ex);
                ex_sum += ex;
            end
            finishGame(ex_sum);
        end

        $display("[TB] reset in the middle of LISTEN");
        startGame(1'b1);
        bus.letter_ready_i = 1'b1;
        waitFor(1, "dec_en_before_reset");
        bus.letter_ready_i = 1'b0;
        step();
        step();
        #2;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        #1;
        checkOutput("midrst_dec_en", bus.dec_en_o, 0);
        checkOutput("midrst_round", bus.round_o, 0);
        checkOutput("midrst_score", bus.score_o, 0);
        checkOutput("midrst_result_valid", bus.result_valid_o, 0);
        checkOutput("midrst_result_ok", bus.result_ok_o, 0);
        checkOutput("midrst_busy", bus.busy_o, 0);
        checkOutput("midrst_letter_req", bus.letter_req_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step();
        checkOutput("post_reset_idle", bus.busy_o, 0);
        checkOutput("post_reset_game_over", bus.game_over_o, 0);

        checkOutput("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete (got timeout, want finish)");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
